// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_if
//  Purpose  : Instruction-memory request/response and decode-side handshake
//             bundle for the fetch queue.
//  Revision : 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] inst_pcplus4;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pcplus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pcplus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : In-order fetch queue between the PC and decode with flush squash.
//             Optional macro FETCH_QUEUE_PERF_EN adds stall/drop counters.
//  Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  wire logic          CLK,
    input  wire logic          Reset,
    input  wire logic [AW-1:0] PC,
    output logic               PCEn,
    input  wire logic          Flush,
    fetch_queue_if.master      bus
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_drops
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW:0]   C_DEPTH_W = (CW+1)'(DEPTH);

    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] filled_q;
    logic [AW-1:0]    pc_q   [DEPTH];
    logic [AW-1:0]    pc4_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    logic [PW-1:0] head_q, tail_q, fill_q, head_d, tail_d, fill_d;
    logic [CW-1:0] alloc_cnt_q, pending_q, drop_q;
    logic [CW-1:0] alloc_cnt_d, pending_d, drop_d;

    logic [CW:0] w_outstanding;
    logic        w_req_valid, w_fire, w_fill, w_drop, w_pop, w_inst_valid;

    assign w_outstanding = {1'b0, pending_q} + {1'b0, drop_q};
    assign w_req_valid   = !Reset && !Flush && (alloc_cnt_q < C_DEPTH) && (w_outstanding < C_DEPTH_W);
    assign w_fire        = w_req_valid && bus.imem_req_ready;
    // Responses with nothing outstanding are protocol errors and fall through both terms.
    assign w_drop        = bus.imem_resp_valid && (drop_q != '0);
    assign w_fill        = bus.imem_resp_valid && (drop_q == '0) && (pending_q != '0);
    assign w_inst_valid  = alloc_q[head_q] && filled_q[head_q];
    assign w_pop         = w_inst_valid && bus.inst_ready;

    assign PCEn              = w_fire || (Flush && !Reset);
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = PC;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst           = data_q[head_q];
    assign bus.inst_pc        = pc_q[head_q];
    assign bus.inst_pcplus4   = pc4_q[head_q];

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        alloc_cnt_d = alloc_cnt_q;
        pending_d   = pending_q;
        drop_d      = drop_q;
        if (Flush) begin
            head_d      = '0;
            tail_d      = '0;
            fill_d      = '0;
            alloc_cnt_d = '0;
            pending_d   = '0;
            // A response landing in the flush cycle is itself one of the squashed ones.
            if (w_outstanding != '0)
                drop_d = w_outstanding[CW-1:0] - CW'(bus.imem_resp_valid);
            else
                drop_d = '0;
        end else begin
            tail_d      = tail_q + PW'(w_fire);
            fill_d      = fill_q + PW'(w_fill);
            head_d      = head_q + PW'(w_pop);
            alloc_cnt_d = alloc_cnt_q + CW'(w_fire) - CW'(w_pop);
            pending_d   = pending_q + CW'(w_fire) - CW'(w_fill);
            drop_d      = drop_q - CW'(w_drop);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            pending_q   <= '0;
            drop_q      <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            alloc_cnt_q <= alloc_cnt_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            alloc_q  <= '0;
            filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                pc4_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (Flush) begin
            alloc_q  <= '0;
            filled_q <= '0;
        end else begin
            if (w_fire) begin
                alloc_q[tail_q]  <= 1'b1;
                filled_q[tail_q] <= 1'b0;
                pc_q[tail_q]     <= PC;
                pc4_q[tail_q]    <= PC + AW'(4);
            end
            if (w_fill) begin
                filled_q[fill_q] <= 1'b1;
                data_q[fill_q]   <= bus.imem_resp_data;
            end
            if (w_pop) begin
                alloc_q[head_q]  <= 1'b0;
                filled_q[head_q] <= 1'b0;
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_q, drops_q;
    logic        w_stall, w_discard;

    assign w_stall   = bus.inst_ready && !w_inst_valid;
    assign w_discard = bus.imem_resp_valid && (Flush ? (w_outstanding != '0) : (drop_q != '0));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            if (w_stall && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (w_discard && (drops_q != '1))
                drops_q <= drops_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_drops  = drops_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue with a fixed-latency
//             in-order memory and a PC register modelled in the stimulus.
//  Revision : 1.0
// ============================================================================
module tb_fetch_queue;
    logic        CLK;
    logic        Reset;
    logic [31:0] PC;
    logic        PCEn;
    logic        Flush;
    logic [31:0] tgt;
    int          checks;
    int          errors;
    int          cnt;
    int          lat;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    fetch_queue_if #(.AW(32), .DW(32)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_drops;
`endif

    fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .PC    (PC),
        .PCEn  (PCEn),
        .Flush (Flush),
        .bus   (bus)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; models the PC register and the in-order memory.
    task automatic cyc();
        logic f, pe, fl;
        f  = bus.imem_req_valid && bus.imem_req_ready;
        pe = PCEn;
        fl = Flush;
        if (f && !Reset) begin
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(cnt + lat);
        end
        @(posedge CLK);
        #1;
        cnt++;
        if (Reset) begin
            PC = 32'h0;
            mq_addr.delete();
            mq_due.delete();
        end else if (pe) begin
            PC = fl ? tgt : PC + 32'd4;
        end
        Flush               = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        if (!Reset && mq_due.size() > 0 && mq_due[0] == cnt) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = dat(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        Reset               = 1'b1;
        Flush               = 1'b0;
        PC                  = 32'h0;
        tgt                 = 32'h0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        mq_addr.delete();
        mq_due.delete();
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        cnt   = 0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt    = 0;
        lat    = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        Reset = 1'b1;
        Flush = 1'b0;
        PC    = 32'h0;
        tgt   = 32'h0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        @(posedge CLK);
        #1;
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
        chk("rst_pcen",       64'(PCEn), 64'd0);
        chk("rst_pcplus4",    64'(bus.inst_pcplus4), 64'd0);

        // Streaming with a 1-cycle memory.
        lat = 1;
        do_reset();
        chk("s1_addr0",  64'(bus.imem_req_addr), 64'h0);
        chk("s1_pcen0",  64'(PCEn), 64'd1);
        chk("s1_iv0",    64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s1_addr1",  64'(bus.imem_req_addr), 64'h4);
        chk("s1_iv1",    64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s1_addr2",  64'(bus.imem_req_addr), 64'h8);
        chk("s1_iv2",    64'(bus.inst_valid), 64'd1);
        chk("s1_pc2",    64'(bus.inst_pc), 64'h0);
        chk("s1_pc4_2",  64'(bus.inst_pcplus4), 64'h4);
        chk("s1_inst2",  64'(bus.inst), 64'(dat(32'h0)));
        cyc();
        chk("s1_pc3",    64'(bus.inst_pc), 64'h4);
        cyc();
        chk("s1_pc4",    64'(bus.inst_pc), 64'h8);
        chk("s1_inst4",  64'(bus.inst), 64'(dat(32'h8)));

        // Decode stalled: queue fills to DEPTH, then PC holds.
        bus.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("s2_fire", 64'(bus.imem_req_valid), 64'd1);
            cyc();
        end
        chk("s2_full_rv",   64'(bus.imem_req_valid), 64'd0);
        chk("s2_full_pcen", 64'(PCEn), 64'd0);
        chk("s2_pc_held",   64'(PC), 64'h10);
        chk("s2_head",      64'(bus.inst_pc), 64'h0);
        cyc();
        chk("s2_pc_held2",  64'(PC), 64'h10);
        bus.inst_ready = 1'b1;
        #1;
        chk("s2_pop_noissue", 64'(bus.imem_req_valid), 64'd0);
        chk("s2_pop0",      64'(bus.inst_pc), 64'h0);
        cyc();
        chk("s2_resume",    64'(bus.imem_req_valid), 64'd1);
        chk("s2_resume_a",  64'(bus.imem_req_addr), 64'h10);
        chk("s2_pop4",      64'(bus.inst_pc), 64'h4);
        cyc();
        chk("s2_pop8",      64'(bus.inst_pc), 64'h8);
        cyc();
        chk("s2_popC",      64'(bus.inst_pc), 64'hC);
        cyc();
        chk("s2_pop10",     64'(bus.inst_pc), 64'h10);
        chk("s2_pop10_d",   64'(bus.inst), 64'(dat(32'h10)));

        // Flush with two requests in flight, 3-cycle memory.
        lat = 3;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        do_reset();
        cyc();
        cyc();
        bus.imem_req_ready = 1'b0;
        Flush = 1'b1;
        tgt   = 32'h100;
        #1;
        chk("s3_flush_rv",   64'(bus.imem_req_valid), 64'd0);
        chk("s3_flush_pcen", 64'(PCEn), 64'd1);
        cyc();
        chk("s3_iv_c3",   64'(bus.inst_valid), 64'd0);
        chk("s3_pc_tgt",  64'(PC), 64'h100);
        bus.imem_req_ready = 1'b1;
        #1;
        chk("s3_issue",   64'(bus.imem_req_valid), 64'd1);
        chk("s3_issue_a", 64'(bus.imem_req_addr), 64'h100);
        cyc();
        bus.imem_req_ready = 1'b0;
        #1;
        chk("s3_iv_c4", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s3_iv_c5", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s3_iv_c6", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s3_iv_c7",   64'(bus.inst_valid), 64'd1);
        chk("s3_pc_c7",   64'(bus.inst_pc), 64'h100);
        chk("s3_pc4_c7",  64'(bus.inst_pcplus4), 64'h104);
        chk("s3_inst_c7", 64'(bus.inst), 64'(dat(32'h100)));
`ifdef FETCH_QUEUE_PERF_EN
        chk("s3_flush_drops",  64'(flush_drops), 64'd2);
        chk("s3_stall_cycles", 64'(stall_cycles), 64'd7);
`endif

        // Flush coinciding with a returning response, three outstanding.
        lat = 3;
        bus.imem_req_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        bus.imem_req_ready = 1'b0;
        Flush = 1'b1;
        tgt   = 32'h100;
        #1;
        chk("s4_resp_in_flush", 64'(bus.imem_resp_valid), 64'd1);
        chk("s4_flush_rv",      64'(bus.imem_req_valid), 64'd0);
        cyc();
        bus.imem_req_ready = 1'b1;
        #1;
        chk("s4_iv_c4",   64'(bus.inst_valid), 64'd0);
        chk("s4_issue_a", 64'(bus.imem_req_addr), 64'h100);
        chk("s4_issue",   64'(bus.imem_req_valid), 64'd1);
        cyc();
        bus.imem_req_ready = 1'b0;
        #1;
        chk("s4_iv_c5", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s4_iv_c6", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s4_iv_c7", 64'(bus.inst_valid), 64'd0);
        cyc();
        chk("s4_iv_c8",   64'(bus.inst_valid), 64'd1);
        chk("s4_pc_c8",   64'(bus.inst_pc), 64'h100);
        chk("s4_inst_c8", 64'(bus.inst), 64'(dat(32'h100)));

        // Asynchronous reset with three filled entries.
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("s5_iv_pre", 64'(bus.inst_valid), 64'd1);
        Reset = 1'b1;
        PC    = 32'h0;
        bus.imem_resp_valid = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        chk("s5_iv",   64'(bus.inst_valid), 64'd0);
        chk("s5_rv",   64'(bus.imem_req_valid), 64'd0);
        chk("s5_pcen", 64'(PCEn), 64'd0);
        chk("s5_inst", 64'(bus.inst), 64'd0);
        chk("s5_ipc",  64'(bus.inst_pc), 64'd0);
        chk("s5_ipc4", 64'(bus.inst_pcplus4), 64'd0);
        cyc();
        Reset = 1'b0;
        cnt   = 0;
        #1;
        chk("s5_restart_rv", 64'(bus.imem_req_valid), 64'd1);
        chk("s5_restart_a",  64'(bus.imem_req_addr), 64'h0);
        cyc();
        cyc();
        chk("s5_restart_iv", 64'(bus.inst_valid), 64'd1);
        chk("s5_restart_pc", 64'(bus.inst_pc), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
